// File: rtl/fetch_seq_ctrl_pkg.sv
// rtl/fetch_seq_ctrl_pkg.sv - shared state encoding and counter widths for the fetch sequencer
package fetch_seq_ctrl_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_seq_ctrl_downcnt.sv
// rtl/fetch_seq_ctrl_downcnt.sv - loadable down-counter with zero flag (boot and flush timing)
module fetch_seq_ctrl_downcnt
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - IF-stage sequencing: PC select/enable, IF/ID stall/clear, redirect hold
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BOOT_DELAY  = 4,
  parameter int               FLUSH_DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   imem_ready,
  input  logic                   ex_redirect,
  input  logic [WIDTH-1:0]       ex_target,
  input  logic                   id_stall,
  output logic                   imem_req,
  output logic                   pc_en,
  output logic                   pcwrcntl,
  output logic [WIDTH-1:0]       pcbranch,
  output logic                   IFREGstall,
  output logic                   IFREGclear,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] BOOT_LOAD  = CNT_W'(BOOT_DELAY - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);

  fetch_state_t           r_state;
  logic                   r_pend;
  logic [WIDTH-1:0]       r_pend_tgt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  fetch_state_t     w_next;
  logic             w_fetch_like;
  logic             w_redir;
  logic [WIDTH-1:0] w_redir_tgt;
  logic             w_capture;
  logic             w_boot_dec;
  logic             w_boot_zero;
  logic             w_flush_load;
  logic             w_flush_dec;
  logic             w_flush_zero;

  // WAIT with data back and nothing held behaves exactly like FETCH
  assign w_fetch_like = (r_state == ST_FETCH) ||
                        ((r_state == ST_WAIT) && imem_ready && !r_pend);

  always_comb begin
    imem_req     = 1'b0;
    pc_en        = 1'b0;
    pcwrcntl     = 1'b0;
    pcbranch     = RESET_PC;
    IFREGstall   = 1'b0;
    IFREGclear   = 1'b0;
    w_next       = r_state;
    w_redir      = 1'b0;
    w_redir_tgt  = ex_target;
    w_capture    = 1'b0;
    w_boot_dec   = 1'b0;
    w_flush_load = 1'b0;
    w_flush_dec  = 1'b0;
    if (reset) begin
      IFREGclear = 1'b1;
    end else begin
      case (r_state)
        ST_BOOT: begin
          IFREGclear = 1'b1;
          w_boot_dec = 1'b1;
          if (w_boot_zero) w_next = ST_FETCH;
        end
        ST_WAIT: begin
          if (!imem_ready) begin
            imem_req   = 1'b1;
            IFREGclear = 1'b1;
            w_capture  = ex_redirect && !r_pend;
          end else if (r_pend) begin
            w_redir     = 1'b1;
            w_redir_tgt = r_pend_tgt;
          end
        end
        ST_FLUSH: begin
          imem_req   = 1'b1;
          IFREGclear = 1'b1;
          pc_en      = imem_ready;
          if (ex_redirect) w_redir = 1'b1;
          else if (w_flush_zero) w_next = ST_FETCH;
          else w_flush_dec = 1'b1;
        end
        default: ;
      endcase
      if (w_fetch_like) begin
        imem_req = 1'b1;
        if (ex_redirect) begin
          w_redir = 1'b1;
        end else if (!imem_ready) begin
          IFREGclear = 1'b1;
          w_next     = ST_WAIT;
        end else if (id_stall) begin
          IFREGstall = 1'b1;
          w_next     = ST_FETCH;
        end else begin
          pc_en  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      if (w_redir) begin
        imem_req   = 1'b1;
        pcwrcntl   = 1'b1;
        pcbranch   = w_redir_tgt;
        pc_en      = 1'b1;
        IFREGclear = 1'b1;
        IFREGstall = 1'b0;
        if (FLUSH_DEPTH == 1) begin
          w_next = ST_FETCH;
        end else begin
          w_next       = ST_FLUSH;
          w_flush_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_pend      <= 1'b0;
      r_pend_tgt  <= RESET_PC;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_pend     <= 1'b1;
        r_pend_tgt <= ex_target;
      end else if (w_redir) begin
        r_pend <= 1'b0;
      end
      if ((r_state != ST_BOOT) && !pc_en && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_count = r_stall_cnt;

  fetch_seq_ctrl_downcnt #(.W(CNT_W)) u_boot_cnt (
    .i_clk      (clk),
    .i_load     (reset),
    .i_load_val (BOOT_LOAD),
    .i_dec      (w_boot_dec),
    .o_zero     (w_boot_zero)
  );

  fetch_seq_ctrl_downcnt #(.W(CNT_W)) u_flush_cnt (
    .i_clk      (clk),
    .i_load     (w_flush_load),
    .i_load_val (FLUSH_LOAD),
    .i_dec      (w_flush_dec),
    .o_zero     (w_flush_zero)
  );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - self-checking bench for fetch_seq_ctrl (two parameterisations)
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic        id_stall = 1'b0;

  logic [1:0]  req, pen, pcw, stl, clr;
  logic [31:0] pcb [2];
  logic [15:0] sc [2];

  int n_cmp = 0;
  int n_err = 0;

  // reference state, one slot per DUT: cycles left in boot/flush, waiting on memory, held redirect
  int          m_boot [2];
  int          m_flush [2];
  bit          m_wait [2];
  bit          m_pv [2];
  logic [31:0] m_pt [2];
  int          m_cnt [2];

  logic        s_req0, s_pen0, s_pcw0, s_stl0, s_clr0, s_clr1, s_pen1;
  logic [31:0] s_pcb0;

  always #5 clk = ~clk;

  fetch_seq_ctrl #(.WIDTH(32), .BOOT_DELAY(4), .FLUSH_DEPTH(1), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .id_stall(id_stall), .imem_req(req[0]), .pc_en(pen[0]),
    .pcwrcntl(pcw[0]), .pcbranch(pcb[0]), .IFREGstall(stl[0]), .IFREGclear(clr[0]),
    .stall_count(sc[0])
  );

  fetch_seq_ctrl #(.WIDTH(32), .BOOT_DELAY(4), .FLUSH_DEPTH(3), .RESET_PC(32'h1000)) dut1 (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .id_stall(id_stall), .imem_req(req[1]), .pc_en(pen[1]),
    .pcwrcntl(pcw[1]), .pcbranch(pcb[1]), .IFREGstall(stl[1]), .IFREGclear(clr[1]),
    .stall_count(sc[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mstep(input int k);
    int          fd;
    logic [31:0] rpc, t;
    logic        e_req, e_pen, e_pcw, e_stl, e_clr;
    logic [31:0] e_pcb;
    logic [15:0] e_sc;
    bit          take;
    fd    = (k == 0) ? 1 : 3;
    rpc   = (k == 0) ? 32'h0 : 32'h1000;
    e_req = 0; e_pen = 0; e_pcw = 0; e_stl = 0; e_clr = 0;
    e_pcb = rpc;
    e_sc  = 16'(m_cnt[k]);
    if (reset) begin
      e_clr = 1;
      m_boot[k] = 4; m_flush[k] = 0; m_wait[k] = 0; m_pv[k] = 0; m_cnt[k] = 0;
    end else if (m_boot[k] > 0) begin
      e_clr = 1;
      m_boot[k]--;
    end else begin
      e_req = 1;
      take  = 0;
      t     = ex_target;
      if (m_wait[k] && imem_ready && m_pv[k]) begin
        take = 1;
        t    = m_pt[k];
      end else if (ex_redirect && (!m_wait[k] || imem_ready)) begin
        take = 1;
      end
      if (take) begin
        e_pcw = 1; e_pcb = t; e_pen = 1; e_clr = 1;
        m_flush[k] = fd - 1; m_wait[k] = 0; m_pv[k] = 0;
      end else if (m_wait[k] && !imem_ready) begin
        e_clr = 1;
        if (ex_redirect && !m_pv[k]) begin
          m_pv[k] = 1;
          m_pt[k] = ex_target;
        end
      end else if (m_flush[k] > 0) begin
        e_clr = 1;
        e_pen = imem_ready;
        m_flush[k]--;
      end else if (!imem_ready) begin
        e_clr = 1;
        m_wait[k] = 1;
      end else begin
        m_wait[k] = 0;
        if (id_stall) e_stl = 1;
        else e_pen = 1;
      end
      if (!e_pen && m_cnt[k] != 32'hFFFF) m_cnt[k]++;
    end
    chk($sformatf("d%0d_imem_req", k), 32'(req[k]), 32'(e_req));
    chk($sformatf("d%0d_pc_en", k), 32'(pen[k]), 32'(e_pen));
    chk($sformatf("d%0d_pcwrcntl", k), 32'(pcw[k]), 32'(e_pcw));
    chk($sformatf("d%0d_pcbranch", k), pcb[k], e_pcb);
    chk($sformatf("d%0d_IFREGstall", k), 32'(stl[k]), 32'(e_stl));
    chk($sformatf("d%0d_IFREGclear", k), 32'(clr[k]), 32'(e_clr));
    chk($sformatf("d%0d_stall_count", k), 32'(sc[k]), 32'(e_sc));
  endtask

  task automatic cyc(input bit r, input bit rdy, input bit rd, input logic [31:0] t, input bit st);
    reset = r; imem_ready = rdy; ex_redirect = rd; ex_target = t; id_stall = st;
    @(negedge clk);
    s_req0 = req[0]; s_pen0 = pen[0]; s_pcw0 = pcw[0]; s_stl0 = stl[0];
    s_clr0 = clr[0]; s_pcb0 = pcb[0]; s_clr1 = clr[1]; s_pen1 = pen[1];
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic boot_seq();
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
  endtask

  initial begin
    // T1: reset cycle plus four boot cycles, first request on the sixth
    boot_seq();
    chk("t1_boot_req", 32'(s_req0), 32'd0);
    chk("t1_boot_clear", 32'(s_clr0), 32'd1);
    cyc(0, 1, 0, 0, 0);
    chk("t1_first_req", 32'(s_req0), 32'd1);

    // T2: redirect in FETCH
    cyc(0, 1, 1, 32'h100, 0);
    chk("t2_pcwrcntl", 32'(s_pcw0), 32'd1);
    chk("t2_pcbranch", s_pcb0, 32'h100);
    chk("t2_clear", 32'(s_clr0), 32'd1);

    // T3: oldest redirect held through a memory wait
    boot_seq();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h200, 0);
    cyc(0, 0, 1, 32'h300, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t3_pcwrcntl", 32'(s_pcw0), 32'd1);
    chk("t3_pcbranch", s_pcb0, 32'h200);
    chk("t3_stall_count", 32'(sc[0]), 32'd3);
    cyc(0, 1, 0, 0, 0);
    chk("t3_no_300", s_pcb0, 32'h0);

    // T4: redirect beats decode stall
    cyc(0, 1, 1, 32'h400, 1);
    chk("t4_clear", 32'(s_clr0), 32'd1);
    chk("t4_stall", 32'(s_stl0), 32'd0);
    chk("t4_pc_en", 32'(s_pen0), 32'd1);

    // T5: three-deep flush on the second instance
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, (i == 0), 32'h500, 0);
      chk($sformatf("t5_clear_%0d", i), 32'(s_clr1), 32'd1);
    end
    cyc(0, 1, 0, 0, 0);
    chk("t5_after_clear", 32'(s_clr1), 32'd0);
    chk("t5_after_pc_en", 32'(s_pen1), 32'd1);

    // T6: reset while a redirect is held drops it
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h600, 0);
    boot_seq();
    cyc(0, 1, 0, 0, 0);
    chk("t6_no_pcwrcntl", 32'(s_pcw0), 32'd0);
    chk("t6_stall_count", 32'(sc[0]), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
